// File: rtl/rvh_l1d_victim_sel.sv
// Victim-way selector for one L1D bank: per-set tree-PLRU plus a one-entry registered response stage.
// Optional RVH_L1D_VICTIM_LOCK_EN adds a per-way lock mask and a nack output.
module rvh_l1d_victim_sel #(
    parameter int SET_NUM   = 32,
    parameter int WAY_NUM   = 4,
    parameter int SET_IDX_W = $clog2(SET_NUM),
    parameter int WAY_IDX_W = $clog2(WAY_NUM),
    parameter int MESI_W    = 2
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             access_valid_i,
    input  logic [SET_IDX_W-1:0]             access_set_idx_i,
    input  logic [WAY_IDX_W-1:0]             access_way_idx_i,
    input  logic                             victim_req_valid_i,
    output logic                             victim_req_ready_o,
    input  logic [SET_IDX_W-1:0]             victim_req_set_idx_i,
    input  logic [WAY_NUM-1:0][MESI_W-1:0]   victim_mesi_sta_i,
`ifdef RVH_L1D_VICTIM_LOCK_EN
    input  logic [WAY_NUM-1:0]               victim_lock_mask_i,
    output logic                             victim_resp_nack_o,
`endif
    output logic                             victim_resp_valid_o,
    input  logic                             victim_resp_ready_i,
    output logic [WAY_IDX_W-1:0]             victim_resp_way_o,
    output logic                             victim_resp_evict_o,
    output logic                             victim_resp_dirty_o
);

    // MESI encoding shared with the line-state table
    localparam logic [MESI_W-1:0] MESI_INVALID  = MESI_W'(0);
    localparam logic [MESI_W-1:0] MESI_MODIFIED = MESI_W'(3);

    // Point every node on the way's root-to-leaf path away from that way.
    function automatic logic [WAY_NUM-2:0] plru_touch(input logic [WAY_NUM-2:0] bits,
                                                      input logic [WAY_IDX_W-1:0] way);
        plru_touch = bits;
        for (int l = 0; l < WAY_IDX_W; l++) begin
            for (int p = 0; p < (1 << l); p++) begin
                if ((way >> (WAY_IDX_W - l)) == WAY_IDX_W'(p))
                    plru_touch[(1 << l) - 1 + p] = ~way[WAY_IDX_W-1-l];
            end
        end
    endfunction

    function automatic logic [WAY_IDX_W-1:0] plru_victim(input logic [WAY_NUM-2:0] bits);
        plru_victim = '0;
        for (int l = 0; l < WAY_IDX_W; l++) begin
            for (int p = 0; p < (1 << l); p++) begin
                if ((plru_victim >> (WAY_IDX_W - l)) == WAY_IDX_W'(p))
                    plru_victim[WAY_IDX_W-1-l] = bits[(1 << l) - 1 + p];
            end
        end
    endfunction

    function automatic logic [WAY_IDX_W-1:0] lowest_way(input logic [WAY_NUM-1:0] vec);
        lowest_way = '0;
        for (int i = WAY_NUM - 1; i >= 0; i--) begin
            if (vec[i])
                lowest_way = WAY_IDX_W'(i);
        end
    endfunction

    logic [WAY_NUM-2:0]   plru_reg [SET_NUM];
    logic [WAY_NUM-2:0]   plru_next [SET_NUM];
    logic [WAY_NUM-1:0]   way_inv;
    logic [WAY_NUM-1:0]   way_ok;
    logic [WAY_NUM-1:0]   cand_inv;
    logic [WAY_NUM-1:0]   cand_valid;
    logic [WAY_IDX_W-1:0] plru_way;
    logic [WAY_IDX_W-1:0] sel_way;
    logic                 sel_evict;
    logic                 sel_dirty;
    logic                 sel_nack;
    logic                 req_fire;
    logic                 plru_upd;

    logic                 resp_valid_reg;
    logic [WAY_IDX_W-1:0] resp_way_reg;
    logic                 resp_evict_reg;
    logic                 resp_dirty_reg;

    generate
        for (genvar gi = 0; gi < WAY_NUM; gi++) begin : g_way
            assign way_inv[gi] = (victim_mesi_sta_i[gi] == MESI_INVALID);
        end
    endgenerate

`ifdef RVH_L1D_VICTIM_LOCK_EN
    assign way_ok = ~victim_lock_mask_i;
`else
    assign way_ok = '1;
`endif

    assign cand_inv   = way_inv & way_ok;
    assign cand_valid = ~way_inv & way_ok;
    assign plru_way   = plru_victim(plru_reg[victim_req_set_idx_i]);

    always_comb begin
        sel_nack  = ~|way_ok;
        sel_way   = '0;
        sel_evict = 1'b0;
        sel_dirty = 1'b0;
        if (|cand_inv) begin
            sel_way = lowest_way(cand_inv);
        end else if (!sel_nack) begin
            // A locked PLRU pick falls back to the lowest unlocked (necessarily valid) way.
            sel_way   = way_ok[plru_way] ? plru_way : lowest_way(cand_valid);
            sel_evict = 1'b1;
            sel_dirty = (victim_mesi_sta_i[sel_way] == MESI_MODIFIED);
        end
    end

    assign victim_req_ready_o = ~resp_valid_reg | victim_resp_ready_i;
    assign req_fire           = victim_req_valid_i & victim_req_ready_o;
    assign plru_upd           = req_fire & ~sel_nack;

    // Access touch first, victim touch second so the victim wins on shared path bits.
    generate
        for (genvar gi = 0; gi < SET_NUM; gi++) begin : g_set
            logic               access_hit;
            logic               victim_hit;
            logic [WAY_NUM-2:0] after_access;
            assign access_hit   = access_valid_i && (access_set_idx_i == SET_IDX_W'(gi));
            assign victim_hit   = plru_upd && (victim_req_set_idx_i == SET_IDX_W'(gi));
            assign after_access = access_hit ? plru_touch(plru_reg[gi], access_way_idx_i) : plru_reg[gi];
            assign plru_next[gi] = victim_hit ? plru_touch(after_access, sel_way) : after_access;
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < SET_NUM; i++) begin
            if (!rstn)
                plru_reg[i] <= '0;
            else
                plru_reg[i] <= plru_next[i];
        end
    end

`ifdef RVH_L1D_VICTIM_LOCK_EN
    logic resp_nack_reg;
    always_ff @(posedge clk) begin
        if (!rstn)
            resp_nack_reg <= 1'b0;
        else if (req_fire)
            resp_nack_reg <= sel_nack;
    end
    assign victim_resp_nack_o = resp_nack_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            resp_valid_reg <= 1'b0;
            resp_way_reg   <= '0;
            resp_evict_reg <= 1'b0;
            resp_dirty_reg <= 1'b0;
        end else if (req_fire) begin
            resp_valid_reg <= 1'b1;
            resp_way_reg   <= sel_way;
            resp_evict_reg <= sel_evict;
            resp_dirty_reg <= sel_dirty;
        end else if (victim_resp_ready_i) begin
            resp_valid_reg <= 1'b0;
        end
    end

    assign victim_resp_valid_o = resp_valid_reg;
    assign victim_resp_way_o   = resp_way_reg;
    assign victim_resp_evict_o = resp_evict_reg;
    assign victim_resp_dirty_o = resp_dirty_reg;

endmodule
